// File: rtl/vga_timing_gen_pkg.sv
// Shared VGA timing constants and the packed pixel-bus layout for the VGA pipeline.
// Latency: n/a (types and constants only).
// Backpressure: n/a. Drawing stages import this to reuse the active-area sizes.
package vga_timing_gen_pkg;

  // 800x600@60Hz, 40 MHz pixel clock
  localparam int VGA_H_ACTIVE = 800;
  localparam int VGA_H_FP     = 40;
  localparam int VGA_H_SYNC   = 128;
  localparam int VGA_H_BP     = 88;
  localparam int VGA_V_ACTIVE = 600;
  localparam int VGA_V_FP     = 1;
  localparam int VGA_V_SYNC   = 4;
  localparam int VGA_V_BP     = 23;

  localparam int CNT_W = 11;
  localparam int RGB_W = 12;
  localparam int FRAME_CNT_W = 16;

  // Field order, MSB first: {hcount, vcount, hsync, vsync, hblnk, vblnk, rgb}
  typedef struct packed {
    logic [CNT_W-1:0] hcount;
    logic [CNT_W-1:0] vcount;
    logic             hsync;
    logic             vsync;
    logic             hblnk;
    logic             vblnk;
    logic [RGB_W-1:0] rgb;
  } vga_bus_t;

  localparam int VGA_BUS_SIZE = 2 * CNT_W + 4 + RGB_W;

endpackage

// File: rtl/vga_timing_gen_axis_cnt.sv
// One timing axis: position counter with blank and sync flags decoded from the next position.
// Latency: flags are registered together with the count, so they always describe the shown count.
// Backpressure: adv low holds count and flags; wrap is adv qualified on the last position.
module vga_axis_cnt
  import vga_timing_gen_pkg::*;
#(
  parameter int ACTIVE   = 800,
  parameter int FP       = 40,
  parameter int SYNC     = 128,
  parameter int BP       = 88,
  parameter bit SYNC_POL = 1'b1
) (
  input  logic             pclk,
  input  logic             rst_n,
  input  logic             adv,
  output logic [CNT_W-1:0] cnt,
  output logic             wrap,
  output logic             blnk,
  output logic             sync
);

  localparam int TOTAL = ACTIVE + FP + SYNC + BP;
  localparam logic [CNT_W-1:0] LAST    = CNT_W'(TOTAL - 1);
  localparam logic [CNT_W-1:0] ACT_END = CNT_W'(ACTIVE);
  localparam logic [CNT_W-1:0] SYNC_LO = CNT_W'(ACTIVE + FP);
  localparam logic [CNT_W-1:0] SYNC_HI = CNT_W'(ACTIVE + FP + SYNC - 1);

  logic             at_last;
  logic [CNT_W-1:0] cnt_nxt;
  logic             blnk_nxt;
  logic             sync_nxt;

  assign at_last  = (cnt == LAST);
  assign wrap     = adv & at_last;
  assign cnt_nxt  = at_last ? '0 : cnt + 1'b1;
  assign blnk_nxt = (cnt_nxt >= ACT_END);
  assign sync_nxt = ((cnt_nxt >= SYNC_LO) && (cnt_nxt <= SYNC_HI)) ? SYNC_POL : ~SYNC_POL;

  // Advance the position and load flags decoded from the new position in the same edge.
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      blnk <= 1'b0;
      sync <= ~SYNC_POL;
    end else if (adv) begin
      cnt  <= cnt_nxt;
      blnk <= blnk_nxt;
      sync <= sync_nxt;
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// Head of the VGA pipeline: pixel position plus sync/blank timing on a packed bus (rgb left at 0).
// Latency: all bus fields registered and coherent; first advance after reset shows (1,0).
// Backpressure: en low freezes every output. Optional frame counter: VGA_TIMING_FRAME_CNT_EN.
module vga_timing_gen
  import vga_timing_gen_pkg::*;
#(
  parameter int H_ACTIVE = VGA_H_ACTIVE,
  parameter int H_FP     = VGA_H_FP,
  parameter int H_SYNC   = VGA_H_SYNC,
  parameter int H_BP     = VGA_H_BP,
  parameter int V_ACTIVE = VGA_V_ACTIVE,
  parameter int V_FP     = VGA_V_FP,
  parameter int V_SYNC   = VGA_V_SYNC,
  parameter int V_BP     = VGA_V_BP,
  parameter bit SYNC_POL = 1'b1
) (
  input  logic                    pclk,
  input  logic                    rst_n,
  input  logic                    en,
`ifdef VGA_TIMING_FRAME_CNT_EN
  output logic                    frame_start,
  output logic [FRAME_CNT_W-1:0]  frame_cnt,
`endif
  output logic [VGA_BUS_SIZE-1:0] vga_out
);

  logic [CNT_W-1:0] hcount;
  logic [CNT_W-1:0] vcount;
  logic             h_wrap;
  logic             v_wrap;
  logic             hblnk;
  logic             vblnk;
  logic             hsync;
  logic             vsync;
  vga_bus_t         bus;

  vga_axis_cnt #(
    .ACTIVE   (H_ACTIVE),
    .FP       (H_FP),
    .SYNC     (H_SYNC),
    .BP       (H_BP),
    .SYNC_POL (SYNC_POL)
  ) u_h_cnt (
    .pclk  (pclk),
    .rst_n (rst_n),
    .adv   (en),
    .cnt   (hcount),
    .wrap  (h_wrap),
    .blnk  (hblnk),
    .sync  (hsync)
  );

  // Vertical axis steps only on the horizontal wrap, so vsync/vblnk change on hcount=0 boundaries.
  vga_axis_cnt #(
    .ACTIVE   (V_ACTIVE),
    .FP       (V_FP),
    .SYNC     (V_SYNC),
    .BP       (V_BP),
    .SYNC_POL (SYNC_POL)
  ) u_v_cnt (
    .pclk  (pclk),
    .rst_n (rst_n),
    .adv   (en & h_wrap),
    .cnt   (vcount),
    .wrap  (v_wrap),
    .blnk  (vblnk),
    .sync  (vsync)
  );

  assign bus.hcount = hcount;
  assign bus.vcount = vcount;
  assign bus.hsync  = hsync;
  assign bus.vsync  = vsync;
  assign bus.hblnk  = hblnk;
  assign bus.vblnk  = vblnk;
  assign bus.rgb    = '0;
  assign vga_out    = bus;

`ifdef VGA_TIMING_FRAME_CNT_EN
  // Pulse and count on the edge that wraps the frame back to (0,0); reset's (0,0) is not a wrap.
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      frame_start <= 1'b0;
      frame_cnt   <= '0;
    end else begin
      frame_start <= v_wrap;
      if (v_wrap) begin
        frame_cnt <= frame_cnt + 1'b1;
      end
    end
  end
`else
  logic frame_wrap_unused;
  assign frame_wrap_unused = v_wrap;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench: full 800x600 timing instance plus a tiny-geometry instance that wraps frames often.
// Driver pushes expected bus per cycle from an arithmetic position model; monitor pops at negedge.
// Randomized en, a freeze at hcount=839, and an asynchronous mid-line reset are exercised.
module tb_vga_timing_gen;
  import vga_timing_gen_pkg::*;

  // Geometry per instance: 0 = full 800x600, 1 = tiny with active-low sync
  int g_ha[2]  = '{800, 8};
  int g_hf[2]  = '{40, 2};
  int g_hs[2]  = '{128, 3};
  int g_ht[2]  = '{1056, 15};
  int g_va[2]  = '{600, 4};
  int g_vf[2]  = '{1, 1};
  int g_vs[2]  = '{4, 2};
  int g_vt[2]  = '{628, 8};
  bit g_pol[2] = '{1'b1, 1'b0};

  logic pclk = 1'b0;
  logic rst_n;
  logic en;
  logic [VGA_BUS_SIZE-1:0] bus_f, bus_s;
`ifdef VGA_TIMING_FRAME_CNT_EN
  logic fs_f, fs_s;
  logic [15:0] fc_f, fc_s;
`endif

  always #5 pclk = ~pclk;

  vga_timing_gen dut_full (
    .pclk        (pclk),
    .rst_n       (rst_n),
    .en          (en),
`ifdef VGA_TIMING_FRAME_CNT_EN
    .frame_start (fs_f),
    .frame_cnt   (fc_f),
`endif
    .vga_out     (bus_f)
  );

  vga_timing_gen #(
    .H_ACTIVE (8), .H_FP (2), .H_SYNC (3), .H_BP (2),
    .V_ACTIVE (4), .V_FP (1), .V_SYNC (2), .V_BP (1),
    .SYNC_POL (1'b0)
  ) dut_small (
    .pclk        (pclk),
    .rst_n       (rst_n),
    .en          (en),
`ifdef VGA_TIMING_FRAME_CNT_EN
    .frame_start (fs_s),
    .frame_cnt   (fc_s),
`endif
    .vga_out     (bus_s)
  );

  typedef struct packed {
    vga_bus_t    bus;
    logic        fs;
    logic [15:0] fc;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int   mh[2], mv[2], mfc[2];
  bit   mfs[2];
  int   n_checks = 0;
  int   n_pass = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // Expected bus for the position the model currently holds on instance i
  function automatic vga_bus_t model_bus(input int i);
    vga_bus_t b;
    bit hact, vact;
    hact = (mh[i] >= g_ha[i] + g_hf[i]) && (mh[i] < g_ha[i] + g_hf[i] + g_hs[i]);
    vact = (mv[i] >= g_va[i] + g_vf[i]) && (mv[i] < g_va[i] + g_vf[i] + g_vs[i]);
    b.hcount = 11'(mh[i]);
    b.vcount = 11'(mv[i]);
    b.hsync  = g_pol[i] ? hact : !hact;
    b.vsync  = g_pol[i] ? vact : !vact;
    b.hblnk  = (mh[i] >= g_ha[i]);
    b.vblnk  = (mv[i] >= g_va[i]);
    b.rgb    = '0;
    return b;
  endfunction

  task automatic model_step(input int i, input bit r, input bit e);
    if (!r) begin
      mh[i] = 0; mv[i] = 0; mfs[i] = 1'b0; mfc[i] = 0;
    end else if (e) begin
      mh[i] = (mh[i] + 1) % g_ht[i];
      if (mh[i] == 0) mv[i] = (mv[i] + 1) % g_vt[i];
      mfs[i] = (mh[i] == 0) && (mv[i] == 0);
      if (mfs[i]) mfc[i] = (mfc[i] + 1) % 65536;
    end else begin
      mfs[i] = 1'b0;
    end
  endtask

  function automatic vga_bus_t reset_bus(input int i);
    vga_bus_t b;
    b = '0;
    b.hsync = !g_pol[i];
    b.vsync = !g_pol[i];
    return b;
  endfunction

  // One clock of stimulus; asserting reset is checked immediately, between edges
  task automatic cycle(input bit r, input bit e);
    exp_t x;
    @(negedge pclk);
    #1;
    if (rst_n && !r) begin
      rst_n = 1'b0;
      en = e;
      #1;
      check("async_rst_full", bus_f, reset_bus(0));
      check("async_rst_small", bus_s, reset_bus(1));
`ifdef VGA_TIMING_FRAME_CNT_EN
      check("async_rst_fcnt", {fs_s, fc_s}, 17'h0);
`endif
    end
    rst_n = r;
    en = e;
    for (int i = 0; i < 2; i++) begin
      model_step(i, r, e);
      x.bus = model_bus(i);
      x.fs  = mfs[i];
      x.fc  = 16'(mfc[i]);
      if (i == 0) q0.push_back(x);
      else q1.push_back(x);
    end
  endtask

  // Monitor: one expected entry per instance per cycle
  initial begin
    exp_t e;
    forever begin
      @(negedge pclk);
      if (q0.size() > 0) begin
        e = q0.pop_front();
        check("bus_full", bus_f, e.bus);
`ifdef VGA_TIMING_FRAME_CNT_EN
        check("frame_full", {fs_f, fc_f}, {e.fs, e.fc});
`endif
      end
      if (q1.size() > 0) begin
        e = q1.pop_front();
        check("bus_small", bus_s, e.bus);
`ifdef VGA_TIMING_FRAME_CNT_EN
        check("frame_small", {fs_s, fc_s}, {e.fs, e.fc});
`endif
      end
    end
  end

  initial begin
    bit found;
    rst_n = 1'b0;
    en = 1'b0;
    for (int k = 0; k < 2; k++) begin
      mh[k] = 0; mv[k] = 0; mfc[k] = 0; mfs[k] = 1'b0;
    end

    // Reset held 10 cycles with random en
    for (int k = 0; k < 10; k++) cycle(1'b0, 1'($urandom_range(0, 1)));

    // Release and run with mostly-high random enable
    for (int k = 0; k < 3000; k++) cycle(1'b1, $urandom_range(0, 9) != 0);

    // Freeze for 37 cycles just before hsync starts on the full instance
    found = 1'b0;
    for (int k = 0; k < 2000 && !found; k++) begin
      if (mh[0] == 839) found = 1'b1;
      else cycle(1'b1, 1'b1);
    end
    check("reach_h839", 64'(found), 64'd1);
    for (int k = 0; k < 37; k++) cycle(1'b1, 1'b0);
    for (int k = 0; k < 20; k++) cycle(1'b1, 1'b1);

    // Asynchronous reset in the middle of a line, then restart
    found = 1'b0;
    for (int k = 0; k < 2000 && !found; k++) begin
      if (mh[0] == 500) found = 1'b1;
      else cycle(1'b1, 1'b1);
    end
    check("reach_h500", 64'(found), 64'd1);
    for (int k = 0; k < 3; k++) cycle(1'b0, 1'b1);
    for (int k = 0; k < 15000; k++) cycle(1'b1, $urandom_range(0, 19) != 0);

    @(negedge pclk);
    @(negedge pclk);
    check("queue_drained", 64'(q0.size() + q1.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
